// File: rtl/gpio_irq.sv
// gpio_irq: input conditioning and interrupt stage for the GPIO pin block.
//
// Each pin is synchronized (2 flops), glitch-filtered (FILTER_LEN stable
// cycles) and compared against its previous filtered value to detect edge or
// level events. Enabled events latch into PENDING; irq = |(PENDING & IE),
// registered.
//
// Ports:
//   clk      sole clock
//   resetn   asynchronous active-low reset
//   gpio_in  raw pin levels (asynchronous to clk)
//   addr     byte offset: 0x0 IE, 0x4 TYPE, 0x8 POL, 0xC PENDING (W1C)
//   wrstb    nonzero = write (whole register)
//   wdata    write data
//   rdata    registered read data, held between reads
//   valid    access request, held by master until ready
//   ready    one-cycle completion pulse
//   irq      level interrupt

// Per-pin synchronizer + glitch filter + previous-value register.
module gpio_irq_pin #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic pin,
  output logic filt,
  output logic filt_prev
);
  localparam int CW = $clog2(FILTER_LEN) + 1;

  logic          sync1, sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      filt      <= 1'b0;
      filt_prev <= 1'b0;
      cnt       <= '0;
    end else begin
      sync1     <= pin;
      sync2     <= sync1;
      filt_prev <= filt;
      // Any return to the current filtered level restarts the count, so a
      // pulse shorter than FILTER_LEN cycles never propagates.
      if (sync2 == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        filt <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module gpio_irq #(
  parameter int GPIO_NR    = 8,
  parameter int FILTER_LEN = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [GPIO_NR-1:0] gpio_in,
  input  logic [3:0]         addr,
  input  logic [3:0]         wrstb,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  input  logic               valid,
  output logic               ready,
  output logic               irq
);
  localparam logic [1:0] A_IE = 2'd0, A_TYPE = 2'd1, A_POL = 2'd2, A_PEND = 2'd3;

  logic [GPIO_NR-1:0] filt, filt_prev;
  logic [GPIO_NR-1:0] ie, typ, pol, pend;
  logic [GPIO_NR-1:0] lvl, edg, evt, w1c, pend_nxt, wd;
  logic [31:0]        rd_val;
  logic               acc, wr, aligned, wr_en;
  logic               unused_wdata;

  gpio_irq_pin #(.FILTER_LEN(FILTER_LEN)) u_pin [GPIO_NR-1:0] (
    .clk       (clk),
    .resetn    (resetn),
    .pin       (gpio_in),
    .filt      (filt),
    .filt_prev (filt_prev)
  );

  // ready doubles as the "already served" flag: a held valid acts once.
  assign acc          = valid & ~ready;
  assign wr           = |wrstb;
  assign aligned      = (addr[1:0] == 2'b00);
  assign wr_en        = acc & wr & aligned;
  assign wd           = wdata[GPIO_NR-1:0];
  assign unused_wdata = ^wdata;

  assign lvl      = ~(filt ^ pol);
  assign edg      = (filt ^ filt_prev) & lvl;
  assign evt      = (typ & edg) | (~typ & lvl);
  assign w1c      = (wr_en && addr[3:2] == A_PEND) ? wd : '0;
  // Set wins over a same-cycle clear.
  assign pend_nxt = (pend & ~w1c) | (evt & ie);

  always_comb begin
    rd_val = '0;
    if (aligned) begin
      case (addr[3:2])
        A_IE:    rd_val[GPIO_NR-1:0] = ie;
        A_TYPE:  rd_val[GPIO_NR-1:0] = typ;
        A_POL:   rd_val[GPIO_NR-1:0] = pol;
        default: rd_val[GPIO_NR-1:0] = pend;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready <= 1'b0;
      rdata <= '0;
      irq   <= 1'b0;
      ie    <= '0;
      typ   <= '0;
      pol   <= '0;
      pend  <= '0;
    end else begin
      ready <= acc;
      if (acc && !wr) rdata <= rd_val;
      if (wr_en) begin
        case (addr[3:2])
          A_IE:    ie  <= wd;
          A_TYPE:  typ <= wd;
          A_POL:   pol <= wd;
          default: ;
        endcase
      end
      pend <= pend_nxt;
      irq  <= |(pend & ie);
    end
  end
endmodule

// File: tb/tb_gpio_irq.sv
module tb_gpio_irq;
  localparam int N = 8;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [N-1:0]  gpio_in = '0;
  logic [3:0]    addr = '0;
  logic [3:0]    wrstb = '0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic          valid = 1'b0;
  logic          ready;
  logic          irq;

  int tests = 0;
  int fails = 0;

  gpio_irq #(.GPIO_NR(N), .FILTER_LEN(4)) dut (
    .clk(clk), .resetn(resetn), .gpio_in(gpio_in), .addr(addr),
    .wrstb(wrstb), .wdata(wdata), .rdata(rdata), .valid(valid),
    .ready(ready), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  a;
    bit          wr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a posedge; returns just after the edge following ready.
  task automatic bus(input logic [3:0] a, input bit wr, input logic [31:0] d,
                     output logic [31:0] q);
    int n;
    addr = a; wrstb = wr ? 4'hF : 4'h0; wdata = d; valid = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!ready && n < 4);
    if (!ready) begin
      tests++; fails++;
      $display("FAIL bus_timeout: got no ready expected ready within 4 cycles");
    end
    q = rdata;
    valid = 1'b0; wrstb = 4'h0;
    @(posedge clk); #1;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] q, last_rd;
  bit          seen;

  initial begin
    tbl[0]  = '{4'h4, 1'b1, 32'h0000_03FF, 32'h0};
    tbl[1]  = '{4'h4, 1'b0, 32'h0,         32'h0000_00FF};
    tbl[2]  = '{4'h8, 1'b1, 32'h0000_F05A, 32'h0};
    tbl[3]  = '{4'h8, 1'b0, 32'h0,         32'h0000_005A};
    tbl[4]  = '{4'h0, 1'b1, 32'h0000_01A5, 32'h0};
    tbl[5]  = '{4'h0, 1'b0, 32'h0,         32'h0000_00A5};
    tbl[6]  = '{4'h1, 1'b1, 32'h0000_00FF, 32'h0};
    tbl[7]  = '{4'h0, 1'b0, 32'h0,         32'h0000_00A5};
    tbl[8]  = '{4'h2, 1'b0, 32'h0,         32'h0};
    tbl[9]  = '{4'hC, 1'b0, 32'h0,         32'h0};
    tbl[10] = '{4'h0, 1'b1, 32'h0,         32'h0};
    tbl[11] = '{4'h4, 1'b1, 32'h0,         32'h0};
    tbl[12] = '{4'h4, 1'b0, 32'h0,         32'h0};
    tbl[13] = '{4'hC, 1'b0, 32'h0,         32'h0};

    // Reset state
    #12;
    chk("rst_ready", ready, 0);
    chk("rst_irq", irq, 0);
    chk("rst_rdata", rdata, 0);
    @(posedge clk); #1; resetn = 1'b1;
    cyc(1);
    for (int i = 0; i < 4; i++) begin
      bus(4'(i * 4), 1'b0, 32'h0, q);
      chk($sformatf("rst_reg_%0h", i * 4), q, 0);
    end
    chk("rst_irq_after", irq, 0);

    // Held valid: one ready pulse, then ready drops even with valid high
    addr = 4'h0; wrstb = 4'h0; valid = 1'b1;
    @(posedge clk); #1; chk("hold_ready_1", ready, 1);
    @(posedge clk); #1; chk("hold_ready_0", ready, 0);
    valid = 1'b0;
    cyc(1);

    // Register table
    last_rd = 32'h0;
    foreach (tbl[i]) begin
      bus(tbl[i].a, tbl[i].wr, tbl[i].wd, q);
      if (tbl[i].wr) begin
        chk($sformatf("tbl%0d_rdata_held", i), q, last_rd);
      end else begin
        chk($sformatf("tbl%0d_read", i), q, tbl[i].exp);
        last_rd = tbl[i].exp;
      end
    end

    // Rising edge on pin0: irq high exactly after edge 7
    bus(4'h4, 1'b1, 32'h01, q);
    bus(4'h8, 1'b1, 32'h01, q);
    bus(4'h0, 1'b1, 32'h01, q);
    gpio_in[0] = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rise_irq_edge%0d", k), irq, (k == 7) ? 1 : 0);
    end
    bus(4'hC, 1'b0, 32'h0, q);
    chk("rise_pending", q, 32'h01);
    bus(4'hC, 1'b1, 32'h01, q);
    chk("w1c_irq_next", irq, 0);
    seen = 1'b0;
    repeat (10) begin @(posedge clk); #1; if (irq) seen = 1'b1; end
    chk("w1c_irq_stays0", seen, 0);

    // Short pulses: 3 cycles filtered out, 4 cycles accepted
    gpio_in[0] = 1'b0;
    cyc(10);
    bus(4'hC, 1'b0, 32'h0, q);
    chk("fall_no_event", q, 0);
    gpio_in[0] = 1'b1; cyc(3); gpio_in[0] = 1'b0;
    seen = 1'b0;
    repeat (14) begin @(posedge clk); #1; if (irq) seen = 1'b1; end
    chk("pulse3_irq", seen, 0);
    bus(4'hC, 1'b0, 32'h0, q);
    chk("pulse3_pending", q, 0);
    gpio_in[0] = 1'b1; cyc(4); gpio_in[0] = 1'b0;
    cyc(12);
    bus(4'hC, 1'b0, 32'h0, q);
    chk("pulse4_pending", q, 32'h01);
    bus(4'hC, 1'b1, 32'h01, q);
    bus(4'hC, 1'b0, 32'h0, q);
    chk("pulse4_cleared", q, 0);

    // Level-low on pin3
    bus(4'h4, 1'b1, 32'h01, q);
    bus(4'h0, 1'b1, 32'h08, q);
    cyc(2);
    bus(4'hC, 1'b0, 32'h0, q);
    chk("lvl_pending", q, 32'h08);
    bus(4'hC, 1'b1, 32'h08, q);
    bus(4'hC, 1'b0, 32'h0, q);
    chk("lvl_reassert", q, 32'h08);
    gpio_in[3] = 1'b1;
    cyc(10);
    bus(4'hC, 1'b1, 32'h08, q);
    bus(4'hC, 1'b0, 32'h0, q);
    chk("lvl_cleared", q, 0);
    chk("lvl_irq_low", irq, 0);

    // W1C on the same edge as a new rising event: set wins
    bus(4'h0, 1'b1, 32'h01, q);
    gpio_in[0] = 1'b1;
    cyc(12);
    chk("sim_pre_irq", irq, 1);
    gpio_in[0] = 1'b0;
    cyc(10);
    gpio_in[0] = 1'b1;         // next edge is edge 0
    cyc(6);                    // just after edge 5
    bus(4'hC, 1'b1, 32'h01, q); // executes at edge 6, pend set at edge 6
    chk("sim_irq_after", irq, 1);
    cyc(3);
    chk("sim_irq_hold", irq, 1);
    bus(4'hC, 1'b0, 32'h0, q);
    chk("sim_pending", q, 32'h01);

    // Pin5 with IE=0 toggling
    repeat (4) begin gpio_in[5] = ~gpio_in[5]; cyc(8); end
    bus(4'hC, 1'b0, 32'h0, q);
    chk("ie0_pin5", q, 32'h01);

    // Asynchronous reset mid-access and mid-filter
    gpio_in[1] = 1'b1;
    cyc(3);
    addr = 4'hC; wrstb = 4'h0; valid = 1'b1;
    @(posedge clk); #1;
    chk("ar_pre_ready", ready, 1);
    chk("ar_pre_rdata", rdata, 32'h01);
    #3 resetn = 1'b0;
    #1;
    chk("ar_ready", ready, 0);
    chk("ar_irq", irq, 0);
    chk("ar_rdata", rdata, 0);
    @(posedge clk); #1;
    chk("ar_no_access", ready, 0);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("ar_new_access", ready, 1);
    chk("ar_new_rdata", rdata, 0);
    valid = 1'b0;
    gpio_in = '0;
    cyc(1);
    for (int i = 0; i < 3; i++) begin
      bus(4'(i * 4), 1'b0, 32'h0, q);
      chk($sformatf("ar_reg_%0h", i * 4), q, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish by 200us");
    $fatal(1);
  end
endmodule
